// File: rtl/recip_arbiter.sv
// recip_arbiter: round-robin front end sharing one start/done reciprocal engine among N_REQ requesters.
// Define RECIP_ARB_TIMEOUT_EN to add the WAIT watchdog (abort after TIMEOUT cycles, then grant hold-off).
module recip_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int F       = 16,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_y,
    output logic               rsp_invalid,
    output logic               rsp_timeout,
    output logic               eng_start,
    output logic [W-1:0]       eng_x,
    input  logic               eng_done,
    input  logic [W-1:0]       eng_y,
    input  logic               eng_invalid
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || F > W || TIMEOUT < 1) begin : g_bad_params
        $error("recip_arbiter: inconsistent parameters");
    end

    state_t           state, state_nx;
    logic [ID_W-1:0]  last_grant, last_grant_nx, cur_id, cur_id_nx;
    logic [N_REQ-1:0] req_ready_nx;
    logic             eng_start_nx, rsp_valid_nx, rsp_invalid_nx, rsp_timeout_nx;
    logic [W-1:0]     eng_x_nx, rsp_y_nx;
    logic [ID_W-1:0]  rsp_id_nx;
    logic             any_valid, grant_ok;
    logic [ID_W-1:0]  grant_idx;

    // Scan from farthest to nearest so the last hit is the first index after last_grant.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

`ifdef RECIP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx, hold_cnt, hold_cnt_nx;
    logic             hold, hold_nx;
    assign grant_ok = any_valid & ~hold;
`else
    assign grant_ok = any_valid;
`endif

    always_comb begin
        // NOTE: every signal gets its default first so no path can leave one unassigned (no latches).
        state_nx       = state;
        last_grant_nx  = last_grant;
        cur_id_nx      = cur_id;
        req_ready_nx   = '0;
        eng_start_nx   = 1'b0;
        eng_x_nx       = eng_x;
        rsp_valid_nx   = rsp_valid;
        rsp_id_nx      = rsp_id;
        rsp_y_nx       = rsp_y;
        rsp_invalid_nx = rsp_invalid;
        rsp_timeout_nx = rsp_timeout;
`ifdef RECIP_ARB_TIMEOUT_EN
        wait_cnt_nx = wait_cnt;
        hold_nx     = hold;
        hold_cnt_nx = hold_cnt;
        // After an abort, a late done or a full idle timeout releases the grant hold-off.
        if (hold) begin
            if (eng_done) begin
                hold_nx = 1'b0;
            end else if (state == S_IDLE) begin
                if (hold_cnt == CNT_LAST) hold_nx = 1'b0;
                else                      hold_cnt_nx = hold_cnt + 1'b1;
            end
        end
`endif
        case (state)
            S_IDLE: begin
                if (grant_ok) begin
                    req_ready_nx = N_REQ'(1) << grant_idx;
                    eng_x_nx     = req_x[int'(grant_idx)*W +: W];
                    cur_id_nx    = grant_idx;
                    state_nx     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start_nx = 1'b1;
                state_nx     = S_WAIT;
`ifdef RECIP_ARB_TIMEOUT_EN
                wait_cnt_nx  = '0;
`endif
            end
            S_WAIT: begin
                if (eng_done) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_id_nx      = cur_id;
                    rsp_y_nx       = eng_y;
                    rsp_invalid_nx = eng_invalid;
                    rsp_timeout_nx = 1'b0;
                    state_nx       = S_RESP;
                end
`ifdef RECIP_ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_id_nx      = cur_id;
                    rsp_y_nx       = '0;
                    rsp_invalid_nx = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    hold_nx        = 1'b1;
                    hold_cnt_nx    = '0;
                    state_nx       = S_RESP;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx  = 1'b0;
                    last_grant_nx = cur_id;
                    state_nx      = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= ID_W'(N_REQ - 1);
            cur_id      <= '0;
            req_ready   <= '0;
            eng_start   <= 1'b0;
            eng_x       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_y       <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            last_grant  <= last_grant_nx;
            cur_id      <= cur_id_nx;
            req_ready   <= req_ready_nx;
            eng_start   <= eng_start_nx;
            eng_x       <= eng_x_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_id      <= rsp_id_nx;
            rsp_y       <= rsp_y_nx;
            rsp_invalid <= rsp_invalid_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end

`ifdef RECIP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            hold     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            hold     <= hold_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_recip_arbiter.sv
// tb_recip_arbiter: randomized requesters and engine stub; a monitor scores responses against a
// transaction-level round-robin/reciprocal model. Honours RECIP_ARB_TIMEOUT_EN when defined.
module tb_recip_arbiter;
    localparam int N_REQ = 4, W = 32, F = 16, ID_W = 2, TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid, req_ready;
    logic [N_REQ*W-1:0] req_x;
    logic               rsp_valid, rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_y;
    logic               rsp_invalid, rsp_timeout;
    logic               eng_start;
    logic [W-1:0]       eng_x;
    logic               eng_done;
    logic [W-1:0]       eng_y;
    logic               eng_invalid;

    recip_arbiter #(.N_REQ(N_REQ), .W(W), .F(F), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_y(eng_y),
        .eng_invalid(eng_invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    y;
        logic            inv;
        logic            tmo;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [W-1:0] op_q[N_REQ][$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int eng_lat = 10;
    bit eng_hang = 1'b0;
    int rdy_mode = 1;
    int model_last = N_REQ - 1;
    int grant_cnt = 0, start_cnt = 0, rsp_cnt = 0, rsp_seen = 0, start_cyc = 0;
    int reset_gen = 0;
    int acc_cnt[N_REQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine behaviour: y = 1/x in QF, x <= 0 is invalid with y = 0.
    function automatic rsp_t ref_engine(input logic [W-1:0] x, input logic [ID_W-1:0] id);
        rsp_t r;
        r.id  = id;
        r.tmo = 1'b0;
        if (longint'($signed(x)) <= 0) begin
            r.y   = '0;
            r.inv = 1'b1;
        end else begin
            r.y   = W'((64'd1 << (2 * F)) / 64'(x));
            r.inv = 1'b0;
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++)
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        int unsigned r;
        logic [W-1:0] v;
        r = $urandom_range(0, 5);
        v = W'($urandom);
        if (r == 0) return '0;
        if (r == 1) begin
            v[W-1] = 1'b1;
            return v;
        end
        return W'($urandom_range(1, 32'h0100_0000));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: present queued operands, hold until accepted.
    initial begin
        int done_cnt[N_REQ];
        req_valid = '0;
        req_x     = '0;
        for (int i = 0; i < N_REQ; i++) done_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (!rst_n) begin
                    req_valid[i] = 1'b0;
                    done_cnt[i]  = acc_cnt[i];
                end else if (done_cnt[i] != acc_cnt[i]) begin
                    req_valid[i] = 1'b0;
                    done_cnt[i]  = acc_cnt[i];
                end else if (!req_valid[i] && op_q[i].size() > 0) begin
                    req_x[i*W +: W] = op_q[i].pop_front();
                    req_valid[i]    = 1'b1;
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Engine stub: latency eng_lat (random when 0), never answers while eng_hang.
    initial begin
        logic [W-1:0] xc;
        int gen, lat;
        bit hang;
        rsp_t r;
        eng_done = 1'b0; eng_y = '0; eng_invalid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && eng_start) begin
                xc   = eng_x;
                gen  = reset_gen;
                hang = eng_hang;
                lat  = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 8));
                for (int c = 0; c < lat; c++) begin
                    @(negedge clk);
                    if (gen == reset_gen && rst_n) check("eng_x_stable", eng_x, xc);
                end
                if (!hang) begin
                    r = ref_engine(xc, '0);
                    @(posedge clk); #1;
                    eng_done = 1'b1; eng_y = r.y; eng_invalid = r.inv;
                    @(posedge clk); #1;
                    eng_done = 1'b0; eng_y = W'($urandom); eng_invalid = 1'($urandom);
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [N_REQ-1:0] snap_valid, prev_ready;
        logic prev_rv, prev_rr;
        rsp_t prev_rsp, cur, e;
        int g, gi;
        logic [W-1:0] x;
        snap_valid = '0; prev_ready = '0; prev_rv = 1'b0; prev_rr = 1'b0; prev_rsp = '0;
        for (int i = 0; i < N_REQ; i++) acc_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_last = N_REQ - 1;
                snap_valid = '0; prev_ready = '0; prev_rv = 1'b0; prev_rr = 1'b0;
                continue;
            end
            cur = {rsp_id, rsp_y, rsp_invalid, rsp_timeout};
            if (req_ready != '0) begin
                g  = rr_pick(snap_valid, model_last);
                gi = 0;
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gi = i;
                check("grant_id", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
                x = req_x[gi*W +: W];
                if (eng_hang) begin
`ifdef RECIP_ARB_TIMEOUT_EN
                    e = {ID_W'(gi), {W{1'b0}}, 1'b1, 1'b1};
                    exp_q.push_back(e);
`endif
                end else begin
                    exp_q.push_back(ref_engine(x, ID_W'(gi)));
                end
                acc_cnt[gi]++;
                grant_cnt++;
            end
            if (eng_start || prev_ready != '0)
                check("start_after_grant", eng_start, prev_ready != '0);
            if (eng_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (prev_rv && !prev_rr) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_fields", cur, prev_rsp);
            end
            if (rsp_valid) begin
                rsp_seen++;
                check("busy_no_grant", {req_ready, eng_start}, 0);
                if (!prev_rv && rsp_timeout) check("timeout_latency", cyc - start_cyc, TIMEOUT);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rsp_unexpected: got id %0d y 0x%0h required no response", rsp_id, rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", cur.id, e.id);
                    check("rsp_y", cur.y, e.y);
                    check("rsp_invalid", cur.inv, e.inv);
                    check("rsp_timeout", cur.tmo, e.tmo);
                    model_last = int'(e.id);
                end
                rsp_cnt++;
            end
            snap_valid = req_valid; prev_ready = req_ready;
            prev_rv = rsp_valid; prev_rr = rsp_ready; prev_rsp = cur;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_y"}, rsp_y, 0);
        check({tag, "_rsp_invalid"}, rsp_invalid, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_x"}, eng_x, 0);
    endtask

    task automatic wait_rsps(input int target, input int limit, input string name);
        int n = 0;
        while (rsp_cnt < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        check({name, "_rsps_done"}, rsp_cnt >= target, 1);
    endtask

    task automatic do_reset(input string tag);
        for (int i = 0; i < N_REQ; i++) op_q[i].delete();
        @(negedge clk); #2;
        rst_n = 1'b0;
        reset_gen++;
        #1 check_reset(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base, n, s0, g0, seen0, c0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, positive operand.
        eng_lat = 10;
        op_q[1].push_back(32'h0002_0000);
        wait_rsps(1, 200, "single");

        // All requesters continuously valid, rsp_ready high.
        eng_lat = 3;
        base = rsp_cnt;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N_REQ; i++) op_q[i].push_back(rand_op());
        wait_rsps(base + 3 * N_REQ, 1000, "round_robin");

        // Non-positive operand.
        base = rsp_cnt;
        op_q[2].push_back(32'hFFFF_0000);
        op_q[0].push_back(32'h0000_0000);
        wait_rsps(base + 2, 200, "nonpos");

        // Backpressure for 20 cycles.
        rdy_mode = 0;
        base = rsp_cnt;
        g0 = grant_cnt;
        op_q[0].push_back(rand_op());
        op_q[3].push_back(rand_op());
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("bp_rsp_valid_seen", rsp_valid, 1);
        repeat (20) @(posedge clk);
        check("bp_single_grant", grant_cnt, g0 + 1);
        rdy_mode = 1;
        wait_rsps(base + 2, 200, "backpressure");

        // Reset while in WAIT; the stale done must be ignored.
        eng_lat = 15;
        s0 = start_cnt;
        op_q[3].push_back(32'h0004_0000);
        n = 0;
        while (start_cnt == s0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("wait_reached", start_cnt != s0, 1);
        @(posedge clk);
        do_reset("mid_wait");
        seen0 = rsp_seen;
        repeat (30) @(posedge clk);
        check("stale_done_ignored", rsp_seen, seen0);
        base = rsp_cnt;
        eng_lat = 4;
        op_q[2].push_back(rand_op());
        op_q[0].push_back(rand_op());
        wait_rsps(base + 2, 200, "after_reset");

        // Engine never answers.
        eng_hang = 1'b1;
        base = rsp_cnt;
        seen0 = rsp_seen;
        op_q[1].push_back(32'h0001_8000);
`ifdef RECIP_ARB_TIMEOUT_EN
        wait_rsps(base + 1, 300, "abort");
        eng_hang = 1'b0;
        c0 = cyc;
        g0 = grant_cnt;
        op_q[2].push_back(32'h0001_0000);
        n = 0;
        while (grant_cnt == g0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("holdoff_grant_seen", grant_cnt != g0, 1);
        check("holdoff_min_gap", (cyc - c0) >= TIMEOUT - 2, 1);
        wait_rsps(base + 2, 200, "after_holdoff");
`else
        repeat (150) @(posedge clk);
        check("hang_no_rsp", rsp_seen, seen0);
        eng_hang = 1'b0;
        do_reset("after_hang");
`endif

        // Random mix with random ready and engine latency.
        eng_lat = 0;
        rdy_mode = 2;
        base = rsp_cnt;
        for (int t = 0; t < 24; t++) op_q[$urandom_range(0, N_REQ - 1)].push_back(rand_op());
        wait_rsps(base + 24, 3000, "random");

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("start_per_grant", start_cnt, grant_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
